gt_tx_bringup_ctrl: RTL
=======================

# gt_tx_bringup_ctrl

Parametrised TX bring-up and supervision controller for a multi-lane GT wizard instance. It sequences the wizard's full reset, user-clock reset and TX buffer-bypass reset, all from the free-running clock domain. It watches per-lane and global done/error status, retries bring-up after a timeout or a link loss, and reports a clean ready/fault status to the video TX datapath. It sits beside the GT wizard in each QSFP transceiver wrapper.

## Interface
- `LANES`, 4: number of GT lanes; width of the per-lane status inputs.
- `SYNC_STAGES`, 2: flop stages on every status input (min 2).
- `RESET_PULSE`, 16: cycles `gt_reset_all` is held per attempt (min 1).
- `BYPASS_HOLD`, 5: cycles `buffbypass_tx_reset` is held per attempt (min 1).
- `TIMEOUT_CYCLES`, 1000000: per-wait-state timeout, in `clock` cycles.
- `MAX_RETRIES`, 3: failed attempts tolerated before FAULT; 0 = retry forever.

- `clock` in 1: free-running clock; the only clock of the block.
- `reset` in 1: asynchronous, active-high.
- `enable` in 1: level; 1 = bring up and hold link, 0 = return to IDLE.
- `txpmaresetdone` in LANES: per-lane PMA reset done (async).
- `txprgdivresetdone` in LANES: per-lane PRGDIV reset done (async).
- `userclk_tx_active` in 1: wizard user-clock helper active (async).
- `reset_tx_done` in 1: wizard TX reset done (async).
- `buffbypass_tx_done` in 1: buffer-bypass helper done (async).
- `buffbypass_tx_error` in 1: buffer-bypass helper error (async).
- `gt_reset_all` out 1: drives the wizard's `gtwiz_reset_all_in`.
- `userclk_tx_reset` out 1: drives `gtwiz_userclk_tx_reset_in`.
- `buffbypass_tx_reset` out 1: drives `gtwiz_buffbypass_tx_reset_in`.
- `tx_ready` out 1: link up; `tx_reset` for the datapath is its inverse.
- `fault` out 1: retries exhausted.
- `retry_count` out 8: failed attempts since leaving IDLE, saturating at 255.
- `state` out 3: current state encoding, for debug/ILA.

## Operation
- All async inputs pass through `SYNC_STAGES` flops before use. `pma_ok` = AND of all synced `txpmaresetdone` and `txprgdivresetdone` bits.
- All outputs are registered. Reset values: `gt_reset_all`=1, `userclk_tx_reset`=1, `buffbypass_tx_reset`=1, `tx_ready`=0, `fault`=0, `retry_count`=0, `state`=IDLE.
- IDLE (0): all three resets asserted and `retry_count` cleared. `enable`=1 → RESET_GT.
- RESET_GT (1): `gt_reset_all`=1 for exactly `RESET_PULSE` cycles, then → WAIT_PMA.
- WAIT_PMA (2): `gt_reset_all`=0. `userclk_tx_reset` = !`pma_ok`, registered. Once `pma_ok` is true → WAIT_USERCLK.
- WAIT_USERCLK (3): synced `userclk_tx_active`=1 → BYPASS_RST.
- BYPASS_RST (4): `buffbypass_tx_reset`=1 for exactly `BYPASS_HOLD` cycles, then → WAIT_BYPASS.
- WAIT_BYPASS (5): `buffbypass_tx_reset`=0. Synced `reset_tx_done` & `buffbypass_tx_done` → READY.
- READY (6): `tx_ready`=1. Monitors for link loss.
- FAULT (7): all three resets asserted, `fault`=1. Exits only on `enable`=0 (→ IDLE) or `reset`.
- Failure events:
  - timeout counter reaches `TIMEOUT_CYCLES` in WAIT_PMA, WAIT_USERCLK or WAIT_BYPASS; the counter clears on every state change;
  - synced `buffbypass_tx_error`=1 in WAIT_BYPASS or READY;
  - in READY, loss of `pma_ok`, `userclk_tx_active`, `reset_tx_done` or `buffbypass_tx_done`.
- On a failure event:
  - if `MAX_RETRIES`≠0 and `retry_count` ≥ `MAX_RETRIES` → FAULT;
  - otherwise `retry_count`+1 (saturating) and → RESET_GT.
- `enable`=0 in any state → IDLE on the next edge; this has priority over every other transition.
- Simultaneous events in one cycle: a failure event has priority over a progress transition.
- `reset` mid-operation: all flops return to reset values immediately (async).

## Timing
- Status input to state-decision latency: `SYNC_STAGES` cycles.
- Outputs change on the same edge as `state`; no combinational paths from input to output.
- Minimum time from `enable` rising to `tx_ready`, with all status inputs already true: 1 + `RESET_PULSE` + 1 + 1 + `BYPASS_HOLD` + 1 cycles, plus sync latency.
- `tx_ready` falls on the edge that leaves READY.
- Consumers in the `tx_clock` domain must synchronize `tx_ready` themselves.

## Structure
- Package `gt_bringup_pkg` holds:
  - the state enum (values 0–7 as listed);
  - `RETRY_W` = 8;
  - a function computing the timeout counter width from `TIMEOUT_CYCLES`.
- Sub-module `sync_bits`: parametrised width × stages flop synchronizer with async reset to 0. Instantiate once for the concatenated status bus (2·`LANES`+4 bits).
- One FSM with a shared down-counter for the pulse, hold and timeout durations.

## Test plan
Bench parameters: `LANES`=4, `RESET_PULSE`=16, `BYPASS_HOLD`=5, `TIMEOUT_CYCLES`=1000, `MAX_RETRIES`=2.
- Clean bring-up: `enable`=1, GT model raises all done bits 50 cycles after `gt_reset_all` falls → `gt_reset_all` high exactly 16 cycles, `buffbypass_tx_reset` high exactly 5 cycles, `tx_ready`=1, `retry_count`=0.
- Lane 2 `txprgdivresetdone` stuck at 0 → timeout after 1000 cycles in WAIT_PMA, `retry_count` reaches 1 then 2, then FAULT with `fault`=1 and all resets asserted.
- `buffbypass_tx_error` pulsed for 3 cycles while in READY → `tx_ready` falls within `SYNC_STAGES`+1 cycles, `retry_count`=1, link returns to READY.
- `enable` dropped in WAIT_BYPASS and in FAULT → IDLE on the next edge, `retry_count`=0, `fault`=0.
- `reset` asserted mid-BYPASS_RST → all outputs take reset values with no clock edge required.
- `userclk_tx_active` and a lane `txpmaresetdone` drop together in READY → exactly one retry counted.

Source files
------------

// File: rtl/gt_bringup_pkg.sv
// Shared types and helpers for the GT TX bring-up controller.
package gt_bringup_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_RESET_GT     = 3'd1,
    ST_WAIT_PMA     = 3'd2,
    ST_WAIT_USERCLK = 3'd3,
    ST_BYPASS_RST   = 3'd4,
    ST_WAIT_BYPASS  = 3'd5,
    ST_READY        = 3'd6,
    ST_FAULT        = 3'd7
  } state_e;

  localparam int RETRY_W = 8;

  // Width of a down-counter that must be able to hold max_count.
  function automatic int cnt_width(input int max_count);
    if (max_count <= 1) return 1;
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/sync_bits.sv
// Multi-bit, multi-stage flop synchronizer for quasi-static status bits.
module sync_bits #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gt_tx_bringup_ctrl.sv
// TX bring-up/supervision FSM for a multi-lane GT wizard: sequences the
// wizard resets, watches done/error status, retries and reports ready/fault.
module gt_tx_bringup_ctrl
  import gt_bringup_pkg::*;
#(
  parameter int LANES          = 4,
  parameter int SYNC_STAGES    = 2,
  parameter int RESET_PULSE    = 16,
  parameter int BYPASS_HOLD    = 5,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic [LANES-1:0]   txpmaresetdone,
  input  logic [LANES-1:0]   txprgdivresetdone,
  input  logic               userclk_tx_active,
  input  logic               reset_tx_done,
  input  logic               buffbypass_tx_done,
  input  logic               buffbypass_tx_error,
  output logic               gt_reset_all,
  output logic               userclk_tx_reset,
  output logic               buffbypass_tx_reset,
  output logic               tx_ready,
  output logic               fault,
  output logic [RETRY_W-1:0] retry_count,
  output logic [2:0]         state
);

  localparam int SYNC_W    = 2 * LANES + 4;
  localparam int CNT_MAX_A = (RESET_PULSE > BYPASS_HOLD) ? RESET_PULSE : BYPASS_HOLD;
  localparam int CNT_MAX   = (TIMEOUT_CYCLES > CNT_MAX_A) ? TIMEOUT_CYCLES : CNT_MAX_A;
  localparam int CNT_W     = cnt_width(CNT_MAX);

  // Counter loads are one less than the duration: the state lasts until it hits zero.
  localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(RESET_PULSE - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(BYPASS_HOLD - 1);
  localparam logic [CNT_W-1:0] TMO_LD   = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [SYNC_W-1:0] status_raw;
  logic [SYNC_W-1:0] status_sync;
  logic              pma_ok;
  logic              uclk_ok;
  logic              rst_done;
  logic              bb_done;
  logic              bb_err;

  assign status_raw = {buffbypass_tx_error, buffbypass_tx_done, reset_tx_done,
                       userclk_tx_active, txprgdivresetdone, txpmaresetdone};

  sync_bits #(
    .WIDTH  (SYNC_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clock),
    .rst (reset),
    .d   (status_raw),
    .q   (status_sync)
  );

  assign pma_ok   = &status_sync[2*LANES-1:0];
  assign uclk_ok  = status_sync[2*LANES];
  assign rst_done = status_sync[2*LANES+1];
  assign bb_done  = status_sync[2*LANES+2];
  assign bb_err   = status_sync[2*LANES+3];

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic               gt_rst_q, gt_rst_d;
  logic               uclk_rst_q, uclk_rst_d;
  logic               bb_rst_q, bb_rst_d;
  logic               ready_q, ready_d;
  logic               fault_q, fault_d;
  logic               cnt_zero;
  logic               fail;

  assign cnt_zero = (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    fail    = 1'b0;

    case (state_q)
      ST_WAIT_PMA, ST_WAIT_USERCLK: fail = cnt_zero;
      ST_WAIT_BYPASS:               fail = cnt_zero | bb_err;
      ST_READY:                     fail = bb_err | ~pma_ok | ~uclk_ok | ~rst_done | ~bb_done;
      default:                      fail = 1'b0;
    endcase

    // Priority: disable, then failure, then forward progress.
    if (!enable) begin
      state_d = ST_IDLE;
    end else if (fail) begin
      if ((MAX_RETRIES != 0) && (retry_q >= RETRY_W'(MAX_RETRIES))) begin
        state_d = ST_FAULT;
      end else begin
        state_d = ST_RESET_GT;
        if (retry_q != '1) retry_d = retry_q + 1'b1;
      end
    end else begin
      case (state_q)
        ST_IDLE:         state_d = ST_RESET_GT;
        ST_RESET_GT:     if (cnt_zero) state_d = ST_WAIT_PMA;
        ST_WAIT_PMA:     if (pma_ok) state_d = ST_WAIT_USERCLK;
        ST_WAIT_USERCLK: if (uclk_ok) state_d = ST_BYPASS_RST;
        ST_BYPASS_RST:   if (cnt_zero) state_d = ST_WAIT_BYPASS;
        ST_WAIT_BYPASS:  if (rst_done && bb_done) state_d = ST_READY;
        default:         state_d = state_q;
      endcase
    end

    if (state_d == ST_IDLE) retry_d = '0;
  end

  // One shared down-counter, reloaded on every state change.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q) begin
      case (state_d)
        ST_RESET_GT:                                 cnt_d = PULSE_LD;
        ST_BYPASS_RST:                               cnt_d = HOLD_LD;
        ST_WAIT_PMA, ST_WAIT_USERCLK, ST_WAIT_BYPASS: cnt_d = TMO_LD;
        default:                                     cnt_d = '0;
      endcase
    end else if (!cnt_zero) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Outputs decode the next state so they move on the same edge as state.
  always_comb begin
    gt_rst_d   = 1'b0;
    uclk_rst_d = 1'b0;
    bb_rst_d   = 1'b0;
    ready_d    = 1'b0;
    fault_d    = 1'b0;
    case (state_d)
      ST_IDLE, ST_FAULT: begin
        gt_rst_d   = 1'b1;
        uclk_rst_d = 1'b1;
        bb_rst_d   = 1'b1;
        fault_d    = (state_d == ST_FAULT);
      end
      ST_RESET_GT: begin
        gt_rst_d   = 1'b1;
        uclk_rst_d = 1'b1;
      end
      ST_WAIT_PMA:   uclk_rst_d = ~pma_ok;
      ST_BYPASS_RST: bb_rst_d   = 1'b1;
      ST_READY:      ready_d    = 1'b1;
      default:       ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      retry_q    <= '0;
      gt_rst_q   <= 1'b1;
      uclk_rst_q <= 1'b1;
      bb_rst_q   <= 1'b1;
      ready_q    <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      gt_rst_q   <= gt_rst_d;
      uclk_rst_q <= uclk_rst_d;
      bb_rst_q   <= bb_rst_d;
      ready_q    <= ready_d;
      fault_q    <= fault_d;
    end
  end

  assign gt_reset_all        = gt_rst_q;
  assign userclk_tx_reset    = uclk_rst_q;
  assign buffbypass_tx_reset = bb_rst_q;
  assign tx_ready            = ready_q;
  assign fault               = fault_q;
  assign retry_count         = retry_q;
  assign state               = state_q;

endmodule
